// File: rtl/morse_pkg.sv
// Shared types, constants and the Morse-to-ASCII lookup for the Morse receiver.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    EMIT,
    GAP
  } state_e;

  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [7:0] ERR_CHAR   = 8'h3F;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int unsigned DASH_UNITS       = 2;
  localparam int unsigned LETTER_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS   = 7;

  // pattern holds the first symbol in bit [count-1]; unused upper bits are zero
  function automatic logic [7:0] morse_to_ascii(input logic [3:0] count,
                                                input logic [7:0] pattern);
    logic [7:0] ch;
    ch = ERR_CHAR;
    case (count)
      4'd1: begin
        case (pattern[0])
          1'b0:    ch = 8'h45; // E
          default: ch = 8'h54; // T
        endcase
      end
      4'd2: begin
        case (pattern[1:0])
          2'b00:   ch = 8'h49; // I
          2'b01:   ch = 8'h41; // A
          2'b10:   ch = 8'h4E; // N
          default: ch = 8'h4D; // M
        endcase
      end
      4'd3: begin
        case (pattern[2:0])
          3'b000:  ch = 8'h53; // S
          3'b001:  ch = 8'h55; // U
          3'b010:  ch = 8'h52; // R
          3'b011:  ch = 8'h57; // W
          3'b100:  ch = 8'h44; // D
          3'b101:  ch = 8'h4B; // K
          3'b110:  ch = 8'h47; // G
          default: ch = 8'h4F; // O
        endcase
      end
      4'd4: begin
        case (pattern[3:0])
          4'b0000: ch = 8'h48; // H
          4'b0001: ch = 8'h56; // V
          4'b0010: ch = 8'h46; // F
          4'b0100: ch = 8'h4C; // L
          4'b0110: ch = 8'h50; // P
          4'b0111: ch = 8'h4A; // J
          4'b1000: ch = 8'h42; // B
          4'b1001: ch = 8'h58; // X
          4'b1010: ch = 8'h43; // C
          4'b1011: ch = 8'h59; // Y
          4'b1100: ch = 8'h5A; // Z
          4'b1101: ch = 8'h51; // Q
          default: ch = ERR_CHAR;
        endcase
      end
      4'd5: begin
        case (pattern[4:0])
          5'b11111: ch = 8'h30;
          5'b01111: ch = 8'h31;
          5'b00111: ch = 8'h32;
          5'b00011: ch = 8'h33;
          5'b00001: ch = 8'h34;
          5'b00000: ch = 8'h35;
          5'b10000: ch = 8'h36;
          5'b11000: ch = 8'h37;
          5'b11100: ch = 8'h38;
          5'b11110: ch = 8'h39;
          default:  ch = ERR_CHAR;
        endcase
      end
      default: ch = ERR_CHAR;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Small character FIFO with valid/ready output and a registered drop pulse.
module morse_char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             drop_q, drop_d;
  logic             full, empty, pop, accept;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = !empty && out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign accept = push && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(accept);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    drop_d   = push && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign drop      = drop_q;

endmodule

// File: rtl/morse_rx_channel.sv
// Single-channel Morse receiver: sync/debounce, press/gap timing, letter assembly,
// ASCII lookup and output FIFO.
module morse_rx_channel
  import morse_pkg::*;
#(
  parameter int unsigned CLK_PER_UNIT    = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MAX_SYMBOLS     = 6,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned DASH_THR = DASH_UNITS * CLK_PER_UNIT;
  localparam int unsigned LGAP_THR = LETTER_GAP_UNITS * CLK_PER_UNIT;
  localparam int unsigned WGAP_THR = WORD_GAP_UNITS * CLK_PER_UNIT;
  localparam int unsigned TW       = $clog2(WGAP_THR + 1);
  localparam int unsigned DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CW       = $clog2(MAX_SYMBOLS + 1);
  localparam int unsigned PW       = MAX_SYMBOLS;

  localparam logic [TW-1:0] DASH_LAST = TW'(DASH_THR - 1);
  localparam logic [TW-1:0] LGAP_MAX  = TW'(LGAP_THR);
  localparam logic [TW-1:0] WGAP_MAX  = TW'(WGAP_THR);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] SYM_MAX   = CW'(MAX_SYMBOLS);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [TW-1:0] dur_q, dur_d;

  state_e        state_q, state_d;
  logic [CW-1:0] sym_cnt_q, sym_cnt_d;
  logic [PW-1:0] pattern_q, pattern_d;
  logic          err_q, err_d;
  logic          space_done_q, space_done_d;
  logic          push_q, push_d;
  logic [7:0]    push_char_q, push_char_d;
  logic          busy_q, busy_d;
  logic          sym;

  assign sync_d = {sync_q[0], key_in};

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dur_d = dur_q;
    if (deb_d != deb_q) begin
      dur_d = '0;
    end else if (dur_q != WGAP_MAX) begin
      dur_d = dur_q + 1'b1;
    end
  end

  // dur_q is zero-based, so a press lasted dur_q+1 cycles at its release
  assign sym = (dur_q < DASH_LAST) ? DOT : DASH;

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    pattern_d    = pattern_q;
    err_d        = err_q;
    space_done_d = space_done_q;
    push_d       = 1'b0;
    push_char_d  = push_char_q;
    case (state_q)
      IDLE: begin
        if (deb_d) state_d = MARK;
      end
      MARK: begin
        if (!deb_d) begin
          state_d = SPACE;
          if (!err_q) begin
            pattern_d = (pattern_q << 1) | PW'(sym);
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
      end
      SPACE: begin
        if (deb_d) begin
          state_d = MARK;
          if (sym_cnt_q == SYM_MAX) err_d = 1'b1;
        end else if (dur_q >= LGAP_MAX) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        push_d       = 1'b1;
        push_char_d  = err_q ? ERR_CHAR
                             : morse_to_ascii(4'(sym_cnt_q), 8'(pattern_q));
        sym_cnt_d    = '0;
        pattern_d    = '0;
        err_d        = 1'b0;
        space_done_d = 1'b0;
        state_d      = GAP;
      end
      GAP: begin
        if (deb_d) begin
          state_d = MARK;
        end else if (dur_q == WGAP_MAX && !space_done_q) begin
          push_d       = 1'b1;
          push_char_d  = SPACE_CHAR;
          space_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MARK) || (state_d == SPACE) || (sym_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      deb_q        <= 1'b0;
      deb_cnt_q    <= '0;
      dur_q        <= '0;
      state_q      <= IDLE;
      sym_cnt_q    <= '0;
      pattern_q    <= '0;
      err_q        <= 1'b0;
      space_done_q <= 1'b1;
      push_q       <= 1'b0;
      push_char_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      dur_q        <= dur_d;
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      pattern_q    <= pattern_d;
      err_q        <= err_d;
      space_done_q <= space_done_d;
      push_q       <= push_d;
      push_char_q  <= push_char_d;
      busy_q       <= busy_d;
    end
  end

  assign busy = busy_q;

  morse_char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_char_q),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_char),
    .drop      (overflow)
  );

endmodule

// File: tb/tb_morse_rx_channel.sv
// Directed bench for morse_rx_channel with a dot unit of 10 cycles and 2-cycle debounce.
module tb_morse_rx_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_char;
  logic       overflow;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx[$];
  int ovf_cnt  = 0;
  int busy_cnt = 0;

  morse_rx_channel #(
    .CLK_PER_UNIT   (10),
    .DEBOUNCE_CYCLES(2),
    .MAX_SYMBOLS    (6),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_char (out_char),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) rx.push_back(out_char);
    if (overflow) ovf_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    cycles(n);
  endtask

  task automatic rel(input int n);
    key_in = 1'b0;
    cycles(n);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_in    = 1'b0;
    out_ready = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic check_rx(input string tag, input int base, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = (base + idx < rx.size()) ? rx[base + idx] : 8'hxx;
    check(tag, {24'h0, got}, {24'h0, exp});
  endtask

  int rb;
  int ob;
  int bb;

  initial begin
    do_reset();
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    check("reset_char", {24'h0, out_char}, 32'h0);
    check("reset_ovf", {31'h0, overflow}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    // A, held until out_ready
    rb = rx.size();
    press(10);
    check("a_busy", {31'h0, busy}, 32'h1);
    rel(10); press(30); rel(40);
    check("a_valid", {31'h0, out_valid}, 32'h1);
    check("a_char", {24'h0, out_char}, 32'h41);
    cycles(5);
    check("a_hold", {24'h0, out_char}, 32'h41);
    out_ready = 1'b1;
    cycles(2);
    out_ready = 1'b0;
    check("a_count", rx.size() - rb, 32'd1);
    check_rx("a_rx", rb, 0, 8'h41);
    check("a_empty", {31'h0, out_valid}, 32'h0);

    // E, long gap, T
    do_reset();
    out_ready = 1'b1;
    rb = rx.size();
    press(10); rel(80); press(30); rel(50);
    check("word_count", rx.size() - rb, 32'd3);
    check_rx("word_e", rb, 0, 8'h45);
    check_rx("word_sp", rb, 1, 8'h20);
    check_rx("word_t", rb, 2, 8'h54);

    // seven dots exceed MAX_SYMBOLS
    do_reset();
    out_ready = 1'b1;
    rb = rx.size();
    for (int i = 0; i < 7; i++) begin
      press(10);
      rel(i == 6 ? 40 : 10);
    end
    check("sym_ovf_count", rx.size() - rb, 32'd1);
    check_rx("sym_ovf_char", rb, 0, 8'h3F);

    // unmapped .-.-.-
    do_reset();
    out_ready = 1'b1;
    rb = rx.size();
    for (int i = 0; i < 6; i++) begin
      press((i % 2) == 0 ? 10 : 30);
      rel(i == 5 ? 40 : 10);
    end
    check("unmapped_count", rx.size() - rb, 32'd1);
    check_rx("unmapped_char", rb, 0, 8'h3F);

    // digit 1 = .----
    do_reset();
    out_ready = 1'b1;
    rb = rx.size();
    for (int i = 0; i < 5; i++) begin
      press(i == 0 ? 10 : 30);
      rel(i == 4 ? 40 : 10);
    end
    check("digit1_count", rx.size() - rb, 32'd1);
    check_rx("digit1_char", rb, 0, 8'h31);

    // FIFO full: five E with consumer stalled
    do_reset();
    rb = rx.size();
    ob = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      press(10);
      rel(40);
    end
    check("full_ovf_pulses", ovf_cnt - ob, 32'd1);
    check("full_ovf_now", {31'h0, overflow}, 32'h0);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    check("full_head", {24'h0, out_char}, 32'h45);
    out_ready = 1'b1;
    cycles(8);
    out_ready = 1'b0;
    check("full_pops", rx.size() - rb, 32'd4);
    for (int i = 0; i < 4; i++) check_rx("full_rx", rb, i, 8'h45);
    check("full_drained", {31'h0, out_valid}, 32'h0);

    // single-cycle glitch
    do_reset();
    out_ready = 1'b1;
    rb = rx.size();
    bb = busy_cnt;
    press(1);
    rel(100);
    check("glitch_busy", busy_cnt - bb, 32'd0);
    check("glitch_rx", rx.size() - rb, 32'd0);

    // reset during second symbol of A
    do_reset();
    out_ready = 1'b1;
    rb = rx.size();
    press(10); rel(10); press(15);
    check("midrst_busy_before", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_char", {24'h0, out_char}, 32'h0);
    check("midrst_ovf", {31'h0, overflow}, 32'h0);
    key_in = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(100);
    check("midrst_rx", rx.size() - rb, 32'd0);
    check("midrst_valid_after", {31'h0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
